// File: rtl/node_pkg.sv
// Shared constants and routing encodings for the node port queue.
package node_pkg;

    localparam int NODE_IP_BITWIDTH = 3;
    localparam int INSTR_WIDTH      = 32;

    typedef enum logic [1:0] {
        PORT_A       = 2'b00,
        PORT_LOCAL   = 2'b01,
        PORT_B       = 2'b10,
        PORT_INVALID = 2'b11
    } port_sel_e;

    // Returns one push strobe per queue, ordered {b, local, a}.
    function automatic logic [2:0] route_onehot(input logic valid, input logic [1:0] sel);
        logic [2:0] strobes;
        strobes = 3'b000;
        if (valid) begin
            case (sel)
                PORT_A:     strobes = 3'b001;
                PORT_LOCAL: strobes = 3'b010;
                PORT_B:     strobes = 3'b100;
                default:    strobes = 3'b000;
            endcase
        end
        return strobes;
    endfunction

endpackage

// File: rtl/port_fifo.sv
// First-word-fall-through queue; FIFO_DEPTH must be a power of two so the pointers wrap naturally.
module port_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic                  full
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  do_pop;
    logic                  do_push;

    // A pop frees a slot in the same edge, so a full queue may still accept a push.
    always_comb begin
        valid   = (count != '0);
        full    = (count == FULL_COUNT);
        do_pop  = pop && valid;
        do_push = push && (!full || do_pop);
        data    = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/node_port_queue.sv
// Routes incoming instructions into three independent output queues (ring A, local, ring B).
// Optional feature macro NODE_DROP_COUNT_EN adds a saturating drop_count output.
module node_port_queue
    import node_pkg::*;
#(
    parameter int DATA_WIDTH = INSTR_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] instruction_in,
    input  logic [1:0]            enable_in,
    output logic [DATA_WIDTH-1:0] a_data,
    output logic [DATA_WIDTH-1:0] l_data,
    output logic [DATA_WIDTH-1:0] b_data,
    output logic                  a_valid,
    output logic                  l_valid,
    output logic                  b_valid,
    input  logic                  a_ready,
    input  logic                  l_ready,
    input  logic                  b_ready,
    output logic                  a_full,
    output logic                  l_full,
    output logic                  b_full
`ifdef NODE_DROP_COUNT_EN
    ,
    output logic [15:0]           drop_count
`endif
);

    logic [2:0] push_sel;
    logic       push_a;
    logic       push_l;
    logic       push_b;

    always_comb begin
        push_sel = route_onehot(valid_in, enable_in);
        push_a   = push_sel[0];
        push_l   = push_sel[1];
        push_b   = push_sel[2];
    end

    port_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo_a (
        .clk       (clk),
        .rst       (rst),
        .push      (push_a),
        .push_data (instruction_in),
        .pop       (a_ready),
        .data      (a_data),
        .valid     (a_valid),
        .full      (a_full)
    );

    port_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo_l (
        .clk       (clk),
        .rst       (rst),
        .push      (push_l),
        .push_data (instruction_in),
        .pop       (l_ready),
        .data      (l_data),
        .valid     (l_valid),
        .full      (l_full)
    );

    port_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo_b (
        .clk       (clk),
        .rst       (rst),
        .push      (push_b),
        .push_data (instruction_in),
        .pop       (b_ready),
        .data      (b_data),
        .valid     (b_valid),
        .full      (b_full)
    );

`ifdef NODE_DROP_COUNT_EN
    logic drop_event;

    // A full queue is only lost to when its consumer is not freeing a slot this edge.
    always_comb begin
        drop_event = (valid_in && (enable_in == PORT_INVALID))
                   || (push_a && a_full && !a_ready)
                   || (push_l && l_full && !l_ready)
                   || (push_b && b_full && !b_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= 16'd0;
        end else if (drop_event && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule
